// File: rtl/vga_pkg.sv
// Shared types and frame constants for the VGA pixel-RAM arbiter.
package vga_pkg;
    localparam int H_PIX = 640;
    localparam int V_PIX = 480;
    localparam int DW    = 12;

    typedef logic [DW-1:0] pixel_t;
    typedef logic [18:0]   vram_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
        pixel_t     data;
    } wr_entry_t;

    function automatic logic in_frame(input logic [8:0] row, input logic [9:0] col,
                                      input int h_pix, input int v_pix);
        return (int'(row) < v_pix) && (int'(col) < h_pix);
    endfunction
endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-request FIFO; storage has no reset, only pointers and level do.
module vram_wr_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push_s, do_pop_s;

    assign full  = (level_q == DEPTH[AW:0]);
    assign empty = (level_q == {(AW+1){1'b0}});
    assign level = level_q;
    assign dout  = mem_q[rptr_q];

    // next pointers, level and storage contents
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        if (do_push_s) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // pointer and level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            level_q <= {(AW+1){1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // entry storage
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/vram_arbiter.sv
// Pixel-RAM arbiter: scan-out reads win every cycle; queued draw writes and the
// full-frame clear engine use only the cycles where scan-out is idle.
module vram_arbiter import vga_pkg::*; #(
    parameter int FIFO_DEPTH = 16,
    parameter int H_PIX      = vga_pkg::H_PIX,
    parameter int V_PIX      = vga_pkg::V_PIX
) (
    input  logic                         vga_clk,
    input  logic                         rst,
    input  logic                         vga_rdn,
    input  logic [8:0]                   vga_row,
    input  logic [9:0]                   vga_col,
    output pixel_t                       vga_pixel,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [8:0]                   wr_row,
    input  logic [9:0]                   wr_col,
    input  pixel_t                       wr_data,
    input  logic                         clr_req,
    input  pixel_t                       clr_color,
    output logic                         clr_busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         oob_flag,
    output vram_addr_t                   ram_addr,
    output logic                         ram_we,
    output pixel_t                       ram_wdata,
    input  pixel_t                       ram_rdata
);
    localparam int EW = $bits(wr_entry_t);

    arb_state_t      state_q, state_d;
    logic [8:0]      row_q, row_d;
    logic [9:0]      col_q, col_d;
    pixel_t          color_q, color_d;
    logic            busy_q, busy_d;
    logic            oob_q, oob_d;

    logic [EW-1:0]   fifo_din_s, fifo_dout_s;
    wr_entry_t       head_s;
    logic            fifo_full_s, fifo_empty_s;
    logic            push_s, pop_s, head_ok_s;

    assign fifo_din_s = {wr_row, wr_col, wr_data};
    assign head_s     = wr_entry_t'(fifo_dout_s);
    assign head_ok_s  = in_frame(head_s.row, head_s.col, H_PIX, V_PIX);
    assign push_s     = wr_valid && !fifo_full_s;
    assign pop_s      = (state_q == DRAIN) && vga_rdn && !fifo_empty_s;
    assign wr_ready   = !fifo_full_s;
    assign clr_busy   = busy_q;
    assign oob_flag   = oob_q;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (vga_clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .level (fifo_level),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // RAM port mux: scan-out owns the port whenever vga_rdn is low
    always_comb begin
        ram_addr  = {vga_row, vga_col};
        ram_we    = 1'b0;
        ram_wdata = head_s.data;
        vga_pixel = {DW{1'b0}};
        if (!vga_rdn) begin
            vga_pixel = ram_rdata;
        end else begin
            case (state_q)
                DRAIN: begin
                    if (!fifo_empty_s) begin
                        ram_addr = {head_s.row, head_s.col};
                        ram_we   = head_ok_s;
                    end else begin
                        ram_we = 1'b0;
                    end
                end
                CLEAR: begin
                    ram_addr  = {row_q, col_q};
                    ram_we    = 1'b1;
                    ram_wdata = color_q;
                end
                default: ram_we = 1'b0;
            endcase
        end
    end

    // arbitration FSM and raster-order clear counters
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        color_d = color_q;
        busy_d  = busy_q;
        oob_d   = oob_q;
        case (state_q)
            IDLE, DRAIN: begin
                if (pop_s && !head_ok_s) begin
                    oob_d = 1'b1;
                end else begin
                    oob_d = oob_q;
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    row_d   = 9'd0;
                    col_d   = 10'd0;
                    color_d = clr_color;
                    busy_d  = 1'b1;
                end else if (fifo_empty_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                if (vga_rdn) begin
                    if (col_q == 10'(H_PIX - 1)) begin
                        col_d = 10'd0;
                        if (row_q == 9'(V_PIX - 1)) begin
                            row_d   = 9'd0;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            row_d = row_q + 9'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end else begin
                    state_d = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, clear and flag registers
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 9'd0;
            col_q   <= 10'd0;
            color_q <= {DW{1'b0}};
            busy_q  <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            oob_q   <= oob_d;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter on a reduced 40x30 frame, with a
// transaction-level model of the write queue and the clear sweep.
module tb_vram_arbiter;
    localparam int TH    = 40;
    localparam int TV    = 30;
    localparam int DEPTH = 16;
    localparam int NPIX  = TH * TV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vga_rdn = 1'b1;
    logic [8:0]  vga_row = 9'd0;
    logic [9:0]  vga_col = 10'd0;
    logic [11:0] vga_pixel;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [8:0]  wr_row = 9'd0;
    logic [9:0]  wr_col = 10'd0;
    logic [11:0] wr_data = 12'd0;
    logic        clr_req = 1'b0;
    logic [11:0] clr_color = 12'd0;
    logic        clr_busy;
    logic [4:0]  fifo_level;
    logic        oob_flag;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata = 12'd0;

    always #5 clk = ~clk;

    vram_arbiter #(.FIFO_DEPTH(DEPTH), .H_PIX(TH), .V_PIX(TV)) dut (
        .vga_clk(clk), .rst(rst), .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col),
        .vga_pixel(vga_pixel), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .clr_req(clr_req), .clr_color(clr_color),
        .clr_busy(clr_busy), .fifo_level(fifo_level), .oob_flag(oob_flag),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    typedef struct { int row; int col; int data; } ent_t;

    ent_t q[$];
    int   mst;            // 0 idle, 1 draining, 2 clearing
    int   cidx;           // pixels written so far by the current clear
    int   ccolor;
    bit   moob;
    int   img [NPIX];     // picture as built from observed RAM writes
    int   dut_writes;
    int   tests = 0;
    int   fails = 0;

    function automatic bit inr(input int row, input int col);
        return (row < TV) && (col < TH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model across the edge.
    task automatic tick();
        bit exp_we;
        int exp_addr, exp_data, nxt, pre_size;
        int r, c;
        @(negedge clk);
        chk("wr_ready", wr_ready, q.size() < DEPTH);
        chk("fifo_level", fifo_level, q.size());
        chk("clr_busy", clr_busy, mst == 2);
        chk("oob_flag", oob_flag, moob);
        exp_we = 1'b0; exp_addr = 0; exp_data = 0;
        if (!vga_rdn) begin
            chk("rd_addr", ram_addr, vga_row * 1024 + vga_col);
            chk("rd_pixel", vga_pixel, ram_rdata);
            chk("rd_we", ram_we, 0);
        end else begin
            chk("blank_pixel", vga_pixel, 0);
            if (mst == 1 && q.size() > 0) begin
                exp_we = inr(q[0].row, q[0].col);
                exp_addr = q[0].row * 1024 + q[0].col;
                exp_data = q[0].data;
            end else if (mst == 2) begin
                exp_we = 1'b1;
                exp_addr = (cidx / TH) * 1024 + (cidx % TH);
                exp_data = ccolor;
            end
            chk("we", ram_we, exp_we);
            if (exp_we) begin
                chk("wr_addr", ram_addr, exp_addr);
                chk("wr_data", ram_wdata, exp_data);
            end
            if (ram_we === 1'b1) begin
                dut_writes++;
                r = int'(ram_addr[18:10]);
                c = int'(ram_addr[9:0]);
                if (inr(r, c)) img[r * TH + c] = int'(ram_wdata);
            end
        end
        pre_size = q.size();
        nxt = mst;
        case (mst)
            0, 1: begin
                if (clr_req) begin
                    nxt = 2; cidx = 0; ccolor = int'(clr_color);
                end else nxt = (pre_size > 0) ? 1 : 0;
            end
            default: begin
                if (vga_rdn) begin
                    cidx++;
                    if (cidx == NPIX) nxt = 0;
                end
            end
        endcase
        if (mst == 1 && vga_rdn && pre_size > 0) begin
            if (!inr(q[0].row, q[0].col)) moob = 1'b1;
            void'(q.pop_front());
        end
        if (wr_valid && pre_size < DEPTH)
            q.push_back('{row: int'(wr_row), col: int'(wr_col), data: int'(wr_data)});
        mst = nxt;
        @(posedge clk);
        #1;
        ram_rdata = 12'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; vga_rdn = 1'b1; wr_valid = 1'b0; clr_req = 1'b0;
        #2;
        chk("rst_we", ram_we, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", wr_ready, 1);
        chk("rst_oob", oob_flag, 0);
        q.delete(); mst = 0; cidx = 0; moob = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input int row, input int col, input int data);
        wr_valid = 1'b1; wr_row = 9'(row); wr_col = 10'(col); wr_data = 12'(data);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        vga_rdn = 1'b1; wr_valid = 1'b0; clr_req = 1'b0;
        while ((q.size() > 0 || mst != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_done_level", fifo_level, 0);
        chk("drain_done_busy", clr_busy, 0);
    endtask

    initial begin
        int w0, bad, k;
        int exp_img [NPIX];
        ent_t during[$];

        mst = 0; cidx = 0; ccolor = 0; moob = 1'b0; dut_writes = 0;
        foreach (img[i]) img[i] = 0;
        @(posedge clk); #1;
        do_reset();

        // scan-out read has priority; a queued write waits
        vga_rdn = 1'b0; vga_row = 9'd10; vga_col = 10'd20; ram_rdata = 12'hABC;
        #1;
        chk("t1_addr", ram_addr, 19'h02814);
        chk("t1_pixel", vga_pixel, 12'hABC);
        chk("t1_we", ram_we, 1'b0);
        push(3, 4, 12'h123);
        for (int i = 0; i < 4; i++) tick();
        drain(50);

        // single write from IDLE
        w0 = dut_writes;
        push(5, 7, 12'h0F0);
        drain(50);
        chk("t2_writes", dut_writes - w0, 1);
        chk("t2_pixel", img[5 * TH + 7], 12'h0F0);

        // fill the queue with scan-out busy, then release
        vga_rdn = 1'b0;
        for (int i = 0; i < 17; i++) push(i, i + 1, 12'h100 + i);
        chk("t3_level16", fifo_level, 16);
        chk("t3_ready0", wr_ready, 0);
        w0 = dut_writes;
        drain(100);
        chk("t3_writes", dut_writes - w0, 16);

        // out-of-range entries are discarded and flagged; frame corner is kept
        w0 = dut_writes;
        push(480, 0, 12'hBAD); push(0, 640, 12'hBAD);
        push(TV, 0, 12'hBAD);  push(0, TH, 12'hBAD);
        push(TV - 1, TH - 1, 12'h5A5);
        drain(50);
        chk("t4_writes", dut_writes - w0, 1);
        chk("t4_oob", oob_flag, 1);
        chk("t4_corner", img[NPIX - 1], 12'h5A5);
        for (int i = 0; i < 3; i++) tick();
        chk("t4_oob_sticky", oob_flag, 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            vga_rdn  = ($urandom_range(0, 3) != 0);
            vga_row  = 9'($urandom_range(0, 511));
            vga_col  = 10'($urandom_range(0, 1023));
            wr_valid = $urandom_range(0, 1) == 1;
            wr_row   = 9'($urandom_range(0, TV + 2));
            wr_col   = 10'($urandom_range(0, TH + 2));
            wr_data  = 12'($urandom);
            clr_req  = ($urandom_range(0, 199) == 0);
            clr_color = 12'($urandom);
            tick();
        end
        drain(3000);

        // full clear under a scan-out-like read pattern, with draws queued meanwhile
        clr_color = 12'h00F; clr_req = 1'b1; vga_rdn = 1'b0;
        tick();
        clr_req = 1'b0;
        w0 = dut_writes; k = 0;
        while (mst == 2 && k < 20000) begin
            vga_rdn  = (k % 10) >= 8;
            vga_row  = 9'(k / 10 % TV);
            vga_col  = 10'(k % TH);
            clr_req  = (k == 100);
            clr_color = 12'hFFF;
            wr_valid = (k % 300 == 5);
            wr_row   = 9'($urandom_range(0, TV - 1));
            wr_col   = 10'($urandom_range(0, TH - 1));
            wr_data  = 12'($urandom);
            if (wr_valid && q.size() < DEPTH)
                during.push_back('{row: int'(wr_row), col: int'(wr_col), data: int'(wr_data)});
            tick();
            k++;
        end
        chk("t5_clear_writes", dut_writes - w0, NPIX);
        chk("t5_busy_fell", clr_busy, 0);
        chk("t5_queued", fifo_level, during.size());
        drain(100);
        foreach (exp_img[i]) exp_img[i] = 12'h00F;
        foreach (during[i]) exp_img[during[i].row * TH + during[i].col] = during[i].data;
        bad = 0;
        foreach (img[i]) if (img[i] != exp_img[i]) bad++;
        chk("t5_image_bad_pixels", bad, 0);

        // reset in the middle of a clear with writes queued
        clr_color = 12'h0A0; clr_req = 1'b1; vga_rdn = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        vga_rdn = 1'b0;
        push(1, 1, 12'h111); push(2, 2, 12'h222); push(3, 3, 12'h333);
        chk("t6_level3", fifo_level, 3);
        chk("t6_busy", clr_busy, 1);
        w0 = dut_writes;
        do_reset();
        for (int i = 0; i < 30; i++) tick();
        chk("t6_no_writes", dut_writes - w0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
